// File: rtl/aes_request_gate.sv
// Round-robin, token-checked front end for one AES core: grant/refuse in 1 cycle, one operation in flight.
// Requests are held off (no ack) while busy; a stalled core is abandoned after TIMEOUT_CYCLES.
module aes_request_gate #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [3:0]   req,
    input  logic [7:0]   req_token,
    input  logic [511:0] req_plaintext,
    input  logic [127:0] key,
    input  logic [3:0]   allow_mask,
    output logic [3:0]   ack,
    output logic [3:0]   deny,
    output logic         busy,
    output logic         aes_start,
    output logic [127:0] aes_plaintext,
    output logic [127:0] aes_key,
    output logic [1:0]   aes_token,
    input  logic         aes_done,
    input  logic [127:0] aes_ciphertext,
    output logic [3:0]   rsp_valid,
    output logic         rsp_err,
    output logic [127:0] rsp_data
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, REJECT, START, WAIT, RESP} state_t;

    state_t        state;
    logic [1:0]    gnt;
    logic [1:0]    rr_ptr;
    logic [TW-1:0] timer;
    logic          err;

    logic [1:0]    pick;
    logic          pick_vld;
    logic [1:0]    idx;
    logic [1:0]    pick_tok;
    logic [3:0]    gnt_onehot;

    // Walk from the highest offset down so the agent closest to rr_ptr wins.
    always_comb begin
        pick     = rr_ptr;
        pick_vld = 1'b0;
        idx      = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            idx = rr_ptr + 2'(i);
            if (req[idx]) begin
                pick     = idx;
                pick_vld = 1'b1;
            end
        end
    end

    assign pick_tok = req_token[2*pick +: 2];

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            gnt           <= 2'd0;
            rr_ptr        <= 2'd0;
            timer         <= '0;
            err           <= 1'b0;
            aes_plaintext <= '0;
            aes_key       <= '0;
            aes_token     <= 2'd0;
            rsp_data      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        gnt <= pick;
                        if (allow_mask[pick_tok]) begin
                            aes_plaintext <= req_plaintext[128*pick +: 128];
                            aes_key       <= key;
                            aes_token     <= pick_tok;
                            state         <= START;
                        end else begin
                            state <= REJECT;
                        end
                    end
                end
                REJECT: begin
                    rr_ptr <= gnt + 2'd1;
                    state  <= IDLE;
                end
                START: begin
                    rr_ptr <= gnt + 2'd1;
                    timer  <= '0;
                    state  <= WAIT;
                end
                WAIT: begin
                    // Completion takes priority over a timeout landing on the same edge.
                    if (aes_done) begin
                        rsp_data <= aes_ciphertext;
                        err      <= 1'b0;
                        state    <= RESP;
                    end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
                        timer    <= timer + TW'(1);
                        rsp_data <= '0;
                        err      <= 1'b1;
                        state    <= RESP;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign gnt_onehot = 4'b0001 << gnt;
    assign ack        = (state == REJECT || state == START) ? gnt_onehot : 4'b0000;
    assign deny       = (state == REJECT) ? gnt_onehot : 4'b0000;
    assign aes_start  = (state == START);
    assign busy       = (state != IDLE);
    assign rsp_valid  = (state == RESP) ? gnt_onehot : 4'b0000;
    assign rsp_err    = (state == RESP) && err;

endmodule

// File: tb/tb_aes_request_gate.sv
// Directed bench for aes_request_gate with a simple delayed-completion core model.
module tb_aes_request_gate;
    localparam logic [127:0] KEY  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT0  = {16{8'ha0}};
    localparam logic [127:0] PT1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] PT2  = {16{8'hc2}};
    localparam logic [127:0] PT3  = {16{8'hd3}};
    localparam logic [127:0] CT1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CTA  = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [127:0] CTB  = 128'hdeadbeef00000000cafef00d11111111;
    localparam logic [127:0] CTC  = 128'h5555aaaa5555aaaa3333cccc3333cccc;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req;
    logic [7:0]   req_token;
    logic [511:0] req_plaintext;
    logic [127:0] key;
    logic [3:0]   allow_mask;
    logic [3:0]   ack, deny, rsp_valid;
    logic         busy, aes_start, rsp_err, aes_done;
    logic [127:0] aes_plaintext, aes_key, rsp_data, aes_ciphertext;
    logic [1:0]   aes_token;

    int checks = 0;
    int failures = 0;

    // Core model: done is visible core_delay cycles after the aes_start cycle (0 = never).
    int           core_delay;
    int           core_cnt;
    logic [127:0] core_ct;
    logic         model_done;
    logic         force_done;

    always #5 clk = ~clk;

    assign aes_done       = model_done | force_done;
    assign aes_ciphertext = core_ct;

    always @(posedge clk) begin
        if (rst) begin
            model_done <= 1'b0;
            core_cnt   <= 0;
        end else begin
            model_done <= 1'b0;
            if (aes_start && core_delay == 1) begin
                model_done <= 1'b1;
            end else if (aes_start && core_delay > 1) begin
                core_cnt <= core_delay - 1;
            end else if (core_cnt != 0) begin
                core_cnt <= core_cnt - 1;
                if (core_cnt == 1) model_done <= 1'b1;
            end
        end
    end

    aes_request_gate #(.TIMEOUT_CYCLES(64)) dut (
        .clk(clk), .rst(rst), .req(req), .req_token(req_token),
        .req_plaintext(req_plaintext), .key(key), .allow_mask(allow_mask),
        .ack(ack), .deny(deny), .busy(busy), .aes_start(aes_start),
        .aes_plaintext(aes_plaintext), .aes_key(aes_key), .aes_token(aes_token),
        .aes_done(aes_done), .aes_ciphertext(aes_ciphertext),
        .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_data(rsp_data)
    );

    typedef struct {
        logic [3:0]   req;
        logic [7:0]   tok;
        logic [3:0]   mask;
        int           delay;
        logic [127:0] ct;
        logic [3:0]   e_ack;
        logic         e_deny;
        logic         e_err;
        logic [127:0] e_data;
        int           e_rsp_cyc;
        logic [127:0] e_pt;
        logic [1:0]   e_tok;
    } vec_t;

    vec_t tbl[9];

    // Results of the last run_one call.
    int           r_ack_cyc, r_start_cyc, r_start_cnt, r_busy_cnt, r_rsp_cyc, r_rsp_cnt;
    logic [3:0]   r_ack, r_deny, r_rsp;
    logic         r_err, r_idle;
    logic [127:0] r_pt, r_key;
    logic [1:0]   r_tok;

    int ord[4];
    int ack_at[4];
    int got;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ack"}, {120'd0, ack, deny}, 128'd0);
        check({tag, "_ctl"}, {124'd0, busy, aes_start, rsp_err, 1'b0}, 128'd0);
        check({tag, "_rsp_valid"}, {124'd0, rsp_valid}, 128'd0);
        check({tag, "_aes_pt"}, aes_plaintext, 128'd0);
        check({tag, "_aes_key"}, aes_key, 128'd0);
        check({tag, "_aes_tok"}, {126'd0, aes_token}, 128'd0);
        check({tag, "_rsp_data"}, rsp_data, 128'd0);
    endtask

    task run_one(input vec_t v);
        r_ack_cyc = -1; r_start_cyc = -1; r_start_cnt = 0; r_busy_cnt = 0;
        r_rsp_cyc = -1; r_rsp_cnt = 0; r_ack = 0; r_deny = 0; r_rsp = 0;
        r_err = 0; r_idle = 0; r_pt = 0; r_key = 0; r_tok = 0;
        req = v.req; req_token = v.tok; allow_mask = v.mask;
        core_delay = v.delay; core_ct = v.ct;
        for (int c = 1; c <= 150; c++) begin
            @(posedge clk); #1;
            if (busy) r_busy_cnt++;
            if (ack != 0 && r_ack_cyc < 0) begin
                r_ack_cyc = c; r_ack = ack; r_deny = deny;
                req = req & ~ack;
            end
            if (aes_start) begin
                r_start_cnt++; r_start_cyc = c;
                r_pt = aes_plaintext; r_key = aes_key; r_tok = aes_token;
            end
            if (rsp_valid != 0) begin
                r_rsp_cnt++; r_rsp_cyc = c; r_rsp = rsp_valid; r_err = rsp_err;
            end
            if (c > 1 && !busy) begin
                r_idle = 1;
                break;
            end
        end
        req = 4'b0;
    endtask

    task run_multi(input logic [3:0] r, input int n);
        got = 0;
        req = r;
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk); #1;
            if (ack != 0 && got < 4) begin
                for (int k = 0; k < 4; k++) if (ack[k]) ord[got] = k;
                ack_at[got] = c;
                got++;
                req = req & ~ack;
            end
            if (got >= n && !busy) break;
        end
        req = 4'b0;
        check("multi_grant_count", 128'(got), 128'(n));
    endtask

    int bad;

    initial begin
        rst = 1'b1; req = 0; req_token = 0; allow_mask = 0; key = KEY;
        req_plaintext = {PT3, PT2, PT1, PT0};
        core_delay = 0; core_ct = 0; force_done = 0;

        //           req      tok           mask     dly ct    e_ack    dny err e_data rsp  e_pt e_tok
        tbl[0] = '{4'b0001, 8'b00_00_00_00, 4'b0010, 0,  0,   4'b0001, 1, 0, 0,     0,   0,   2'b00};
        tbl[1] = '{4'b0010, 8'b00_00_01_00, 4'b0010, 20, CT1, 4'b0010, 0, 0, CT1,   22,  PT1, 2'b01};
        tbl[2] = '{4'b0100, 8'b00_11_00_00, 4'b1000, 1,  CTA, 4'b0100, 0, 0, CTA,   3,   PT2, 2'b11};
        tbl[3] = '{4'b1000, 8'b10_00_00_00, 4'b0011, 0,  0,   4'b1000, 1, 0, CTA,   0,   0,   2'b00};
        tbl[4] = '{4'b1000, 8'b10_00_00_00, 4'b0100, 0,  CTB, 4'b1000, 0, 1, 0,     66,  PT3, 2'b10};
        tbl[5] = '{4'b0001, 8'b00_00_00_00, 4'b0001, 5,  CTB, 4'b0001, 0, 0, CTB,   7,   PT0, 2'b00};
        tbl[6] = '{4'b0010, 8'b00_00_11_00, 4'b1000, 64, CTC, 4'b0010, 0, 0, CTC,   66,  PT1, 2'b11};
        tbl[7] = '{4'b0100, 8'b00_01_00_00, 4'b0010, 65, CTA, 4'b0100, 0, 1, 0,     66,  PT2, 2'b01};
        tbl[8] = '{4'b0001, 8'b00_00_00_00, 4'b1111, 2,  CTB, 4'b0001, 0, 0, CTB,   4,   PT0, 2'b00};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check_reset_vals("reset");

        for (int i = 0; i < 9; i++) begin
            run_one(tbl[i]);
            check($sformatf("v%0d_idle_return", i), 128'(r_idle), 128'd1);
            check($sformatf("v%0d_ack_cyc", i), 128'(r_ack_cyc), 128'd1);
            check($sformatf("v%0d_ack", i), {124'd0, r_ack}, {124'd0, tbl[i].e_ack});
            check($sformatf("v%0d_deny", i), {124'd0, r_deny},
                  tbl[i].e_deny ? {124'd0, tbl[i].e_ack} : 128'd0);
            check($sformatf("v%0d_rsp_data", i), rsp_data, tbl[i].e_data);
            if (tbl[i].e_deny) begin
                check($sformatf("v%0d_no_start", i), 128'(r_start_cnt), 128'd0);
                check($sformatf("v%0d_no_rsp", i), 128'(r_rsp_cnt), 128'd0);
                check($sformatf("v%0d_busy_cnt", i), 128'(r_busy_cnt), 128'd1);
            end else begin
                check($sformatf("v%0d_start_cyc", i), 128'(r_start_cyc), 128'd1);
                check($sformatf("v%0d_start_cnt", i), 128'(r_start_cnt), 128'd1);
                check($sformatf("v%0d_aes_pt", i), r_pt, tbl[i].e_pt);
                check($sformatf("v%0d_aes_key", i), r_key, KEY);
                check($sformatf("v%0d_aes_tok", i), {126'd0, r_tok}, {126'd0, tbl[i].e_tok});
                check($sformatf("v%0d_rsp_cyc", i), 128'(r_rsp_cyc), 128'(tbl[i].e_rsp_cyc));
                check($sformatf("v%0d_rsp_cnt", i), 128'(r_rsp_cnt), 128'd1);
                check($sformatf("v%0d_rsp_valid", i), {124'd0, r_rsp}, {124'd0, tbl[i].e_ack});
                check($sformatf("v%0d_rsp_err", i), 128'(r_err), 128'(tbl[i].e_err));
                check($sformatf("v%0d_busy_cnt", i), 128'(r_busy_cnt), 128'(tbl[i].e_rsp_cyc));
            end
        end

        // Round-robin after reset: 0,1,2,3 with 1-cycle core at 4-cycle spacing.
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        req_token = 8'b0; allow_mask = 4'b0001; core_delay = 1; core_ct = CTB;
        run_multi(4'b1111, 4);
        for (int k = 0; k < 4; k++) check($sformatf("rr_order%0d", k), 128'(ord[k]), 128'(k));
        check("rr_spacing", 128'(ack_at[1] - ack_at[0]), 128'd4);
        run_multi(4'b0010, 1);
        check("rr_agent1", 128'(ord[0]), 128'd1);
        run_multi(4'b1001, 2);
        check("rr_wrap_first", 128'(ord[0]), 128'd3);
        check("rr_wrap_second", 128'(ord[1]), 128'd0);
        check("rr_data_before_reset", rsp_data, CTB);

        // Reset mid-WAIT, then a late done must not produce a response.
        core_delay = 0; req = 4'b0100;
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk); #1;
            if (ack != 0) req = 4'b0;
        end
        check("midwait_busy", 128'(busy), 128'd1);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        check_reset_vals("midwait_reset");
        force_done = 1'b1;
        @(posedge clk); #1 force_done = 1'b0;
        bad = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (rsp_valid != 0 || busy) bad++;
        end
        check("late_done_ignored", 128'(bad), 128'd0);

        // Done while idle is ignored.
        force_done = 1'b1;
        @(posedge clk); #1 force_done = 1'b0;
        bad = 0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            if (rsp_valid != 0 || busy || ack != 0) bad++;
        end
        check("idle_done_ignored", 128'(bad), 128'd0);

        run_one(tbl[8]);
        check("recover_rsp_valid", {124'd0, r_rsp}, 128'd1);
        check("recover_rsp_data", rsp_data, CTB);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/aes_request_gate.md
# aes_request_gate

Upstream front end for the AES encryption core: arbitrates encryption requests from four agents, checks each agent's 2-bit access token against a permitted-token mask, and launches only authorised operations on the core. It drives the core's start, plaintext, key and token inputs, waits for completion, and returns the ciphertext (or a timeout error) to the requesting agent. Unauthorised requests are refused before the core is touched.

## Interface

- TIMEOUT_CYCLES, 64: maximum WAIT-state cycles before the operation is abandoned; must be ≥ 2.
- clk  in  1  clock; all logic rises on posedge clk.
- rst  in  1  reset, synchronous, active-high.
- req  in  4  request level, one bit per agent.
- req_token  in  8  agent i token at bits [2i+1:2i].
- req_plaintext  in  512  agent i plaintext at bits [128i+127:128i].
- key  in  128  shared key, sampled at grant.
- allow_mask  in  4  bit t set ⇒ token value t is authorised.
- ack  out  4  one-cycle pulse: request for agent i accepted or refused.
- deny  out  4  one-cycle pulse coincident with ack when refused.
- busy  out  1  high in every state except IDLE.
- aes_start  out  1  one-cycle start pulse to the core.
- aes_plaintext  out  128  latched plaintext to the core.
- aes_key  out  128  latched key to the core.
- aes_token  out  2  latched token to the core.
- aes_done  in  1  core completion pulse.
- aes_ciphertext  in  128  core result, valid with aes_done.
- rsp_valid  out  4  one-cycle pulse to agent i with the result.
- rsp_err  out  1  high with rsp_valid on timeout.
- rsp_data  out  128  ciphertext; held until the next response.

## Operation

- States: IDLE, REJECT, START, WAIT, RESP.
- IDLE: if any req bit is high, select agent g by round-robin starting at rr_ptr (search rr_ptr, rr_ptr+1, … mod 4). If allow_mask[token_g] = 1, latch plaintext_g, key and token_g into aes_* registers and go to START; otherwise go to REJECT. If no req, stay.
- REJECT: ack[g] = deny[g] = 1; rr_ptr ← g+1 mod 4; go to IDLE. aes_* registers unchanged.
- START: ack[g] = 1, aes_start = 1; rr_ptr ← g+1 mod 4; clear timer; go to WAIT.
- WAIT: if aes_done, capture aes_ciphertext into rsp_data and go to RESP with error clear. Otherwise timer increments; when the timer reaches TIMEOUT_CYCLES without aes_done, set rsp_data = 0 and go to RESP with error set.
- RESP: rsp_valid[g] = 1, rsp_err = error flag; go to IDLE.
- aes_done is ignored in every state except WAIT.
- Agents deassert req on the edge at which they observe ack; req is not resampled until the next IDLE cycle.
- Only one operation is outstanding at a time; req bits are ignored while busy.

## Timing

- Reset: state IDLE, rr_ptr = 0, timer = 0; ack, deny, rsp_valid, rsp_err, aes_start and busy = 0; aes_plaintext, aes_key, aes_token and rsp_data = 0.
- Reset asserted in any state takes effect at the next edge: the operation is abandoned, no rsp_valid is produced, and a late aes_done is ignored.
- All outputs are registered or decoded from state/registers only; no input-to-output combinational path.
- Grant latency: req sampled high in IDLE at edge n ⇒ ack and aes_start high in cycle n+1; WAIT from n+2.
- Refusal: req at edge n ⇒ ack and deny in cycle n+1; IDLE again at n+2.
- Response: aes_done sampled in WAIT at edge m ⇒ rsp_valid in cycle m+1; IDLE at m+2.
- Timeout: rsp_valid/rsp_err occur exactly TIMEOUT_CYCLES+1 cycles after the aes_start cycle.
- aes_done arriving on the same edge the timeout fires: done wins, and no error is flagged.
- Minimum grant-to-grant spacing with a 1-cycle core: 4 cycles.

## Test plan

- allow_mask = 4'b0010, agent 0 req with token 2'b00 ⇒ ack[0] = deny[0] = 1 for one cycle, aes_start never asserts, busy high for exactly one cycle.
- Agent 1, token 2'b01, plaintext 00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f; core model pulses done after 20 cycles with 69c4e0d86a7b0430d8cdb78070b4c55a ⇒ aes_start one cycle after req, then rsp_valid[1] = 1, rsp_err = 0, and rsp_data = 69c4e0d86a7b0430d8cdb78070b4c55a.
- After reset, all four agents request with valid tokens ⇒ grants in order 0, 1, 2, 3. Next, after agent 1 is served, agents 0 and 3 request together ⇒ agent 3 is granted first.
- Core never completes, TIMEOUT_CYCLES = 64 ⇒ rsp_valid[g] and rsp_err = 1 occur 65 cycles after aes_start, with rsp_data = 0; the next request is accepted normally.
- rst pulsed for one cycle mid-WAIT, followed by aes_done ⇒ all outputs return to reset values, no rsp_valid is produced, and the state is IDLE.
- aes_done pulsed while in IDLE, and aes_done coincident with the timeout edge ⇒ the first is ignored; the second produces a normal response with rsp_err = 0.
